// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding request at a time
// to instruction memory, and buffers returned {PC, Inst} entries for decode.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Redirect,
  input  logic [31:0]              RedirTarget,
  output logic                     IMem_Req,
  output logic [31:0]              IMem_Addr,
  input  logic                     IMem_Ack,
  input  logic [31:0]              IMem_Data,
  input  logic                     D_Ready,
  output logic                     D_Valid,
  output logic [31:0]              D_PC,
  output logic [31:0]              D_PC4,
  output logic [31:0]              D_Inst,
  output logic                     dbg_discard,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {FETCH = 1'b0, DISCARD = 1'b1} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pend_addr;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic ack_taken;
  logic push;
  logic pop;

  // Handshakes: memory side completes when IMem_Req & IMem_Ack in the same cycle, and Req/Addr
  // hold until then; decode side transfers the head when D_Valid & D_Ready at the clock edge.
  assign IMem_Req  = Rst_n && ((state == FETCH && count < FULL) || state == DISCARD);
  assign IMem_Addr = (state == DISCARD) ? pend_addr : fetch_pc;

  assign ack_taken = IMem_Req && IMem_Ack;
  assign push      = (state == FETCH) && ack_taken && !Redirect;
  assign pop       = D_Valid && D_Ready && !Redirect;

  assign D_Valid = (count != '0);
  assign D_PC    = D_Valid ? pc_mem[rd_ptr] : 32'd0;
  assign D_PC4   = D_Valid ? pc_mem[rd_ptr] + 32'd4 : 32'd0;
  assign D_Inst  = D_Valid ? inst_mem[rd_ptr] : NOP_INST;

  assign dbg_discard = (state == DISCARD);
  assign dbg_count   = count;

  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= IMem_Data;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      pend_addr <= 32'd0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (Redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RedirTarget;
      if (state == FETCH) begin
        // An unanswered request must still be completed, so remember its address.
        if (IMem_Req && !IMem_Ack) begin
          state     <= DISCARD;
          pend_addr <= fetch_pc;
        end
      end else if (IMem_Ack) begin
        state <= FETCH;
      end
    end else begin
      if (state == DISCARD && IMem_Ack) begin
        state <= FETCH;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: queue-based reference model compared every cycle,
// plus hand-computed literal checks for each scenario.
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirTarget = 32'd0;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_Data;
  logic        D_Ready = 1'b0;
  logic        D_Valid;
  logic [31:0] D_PC;
  logic [31:0] D_PC4;
  logic [31:0] D_Inst;
  logic        dbg_discard;
  logic [2:0]  dbg_count;

  logic        ack_en = 1'b0;
  logic        data_force_en = 1'b0;
  logic [31:0] data_force = 32'd0;
  logic        cmp_en = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: entries are {pc, inst}
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_pend = 32'd0;
  logic        m_discard = 1'b0;
  logic        m_rq;
  logic        m_ak;
  logic [31:0] m_data;

  assign IMem_Ack  = ack_en;
  assign IMem_Data = data_force_en ? data_force : (IMem_Addr ^ XMASK);

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Redirect(Redirect), .RedirTarget(RedirTarget),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data),
    .D_Ready(D_Ready), .D_Valid(D_Valid), .D_PC(D_PC), .D_PC4(D_PC4), .D_Inst(D_Inst),
    .dbg_discard(dbg_discard), .dbg_count(dbg_count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update
  initial forever begin
    @(posedge Clk or negedge Rst_n);
    if (!Rst_n) begin
      exp_q.delete();
      m_pc = 32'd0;
      m_pend = 32'd0;
      m_discard = 1'b0;
    end else begin
      m_rq = m_discard || (exp_q.size() < DEPTH);
      m_ak = m_rq && IMem_Ack;
      m_data = data_force_en ? data_force : (m_pc ^ XMASK);
      if (Redirect) begin
        if (!m_discard && m_rq && !m_ak) begin
          m_discard = 1'b1;
          m_pend = m_pc;
        end else if (m_discard && m_ak) begin
          m_discard = 1'b0;
        end
        exp_q.delete();
        m_pc = RedirTarget;
      end else if (m_discard) begin
        if (m_ak) m_discard = 1'b0;
      end else begin
        if (exp_q.size() > 0 && D_Ready) void'(exp_q.pop_front());
        if (m_ak) begin
          exp_q.push_back({m_pc, m_data});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge Clk);
    if (cmp_en) begin
      logic        e_req;
      logic [63:0] head;
      e_req = Rst_n && (m_discard || exp_q.size() < DEPTH);
      check("req", IMem_Req, e_req);
      if (e_req) check("addr", IMem_Addr, m_discard ? m_pend : m_pc);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("valid", D_Valid, 1'b1);
        check("d_pc", D_PC, head[63:32]);
        check("d_pc4", D_PC4, head[63:32] + 32'd4);
        check("d_inst", D_Inst, head[31:0]);
      end else begin
        check("valid", D_Valid, 1'b0);
        check("d_pc", D_PC, 32'd0);
        check("d_pc4", D_PC4, 32'd0);
        check("d_inst", D_Inst, NOP);
      end
      check("count", dbg_count, exp_q.size());
      check("discard", dbg_discard, m_discard);
    end
  end

  task automatic next();
    @(negedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Rst_n = 1'b0;
    Redirect = 1'b0;
    RedirTarget = 32'd0;
    ack_en = 1'b0;
    D_Ready = 1'b0;
    data_force_en = 1'b0;
    data_force = 32'd0;
    next();
    next();
  endtask

  initial begin
    // 1: streaming fetch
    apply_reset();
    cmp_en = 1'b1;
    check("rst_req", IMem_Req, 1'b0);
    check("rst_valid", D_Valid, 1'b0);
    check("rst_pc", D_PC, 32'd0);
    check("rst_pc4", D_PC4, 32'd0);
    check("rst_inst", D_Inst, NOP);
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b1;
    next();
    check("t1_pc0", D_PC, 32'h0);
    check("t1_inst0", D_Inst, 32'hA5A5_0000);
    check("t1_pc4_0", D_PC4, 32'h4);
    check("t1_addr4", IMem_Addr, 32'h4);
    next();
    check("t1_pc1", D_PC, 32'h4);
    check("t1_inst1", D_Inst, 32'hA5A5_0004);
    check("t1_addr8", IMem_Addr, 32'h8);
    repeat (6) next();

    // 2: fill while decode stalls, then drain
    apply_reset();
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b0;
    repeat (4) next();
    check("t2_valid", D_Valid, 1'b1);
    check("t2_full", dbg_count, 3'd4);
    check("t2_req_off", IMem_Req, 1'b0);
    check("t2_drain0", D_PC, 32'h0);
    D_Ready = 1'b1;
    next();
    check("t2_drain1", D_PC, 32'h4);
    check("t2_resume_req", IMem_Req, 1'b1);
    check("t2_resume_addr", IMem_Addr, 32'h10);
    ack_en = 1'b0;
    next();
    check("t2_drain2", D_PC, 32'h8);
    next();
    check("t2_drain3", D_PC, 32'hC);
    next();
    check("t2_empty", D_Valid, 1'b0);

    // 3: memory waits three cycles on 0x8
    apply_reset();
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b1;
    next();
    next();
    check("t3_addr8", IMem_Addr, 32'h8);
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next();
      check("t3_hold_req", IMem_Req, 1'b1);
      check("t3_hold_addr", IMem_Addr, 32'h8);
      check("t3_hold_valid", D_Valid, 1'b0);
    end
    ack_en = 1'b1;
    next();
    check("t3_valid", D_Valid, 1'b1);
    check("t3_pc", D_PC, 32'h8);
    check("t3_inst", D_Inst, 32'hA5A5_0008);

    // 4: redirect while 0xC is pending
    apply_reset();
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b0;
    repeat (3) next();
    check("t4_addrC", IMem_Addr, 32'hC);
    check("t4_cnt3", dbg_count, 3'd3);
    ack_en = 1'b0;
    next();
    Redirect = 1'b1; RedirTarget = 32'h40;
    next();
    Redirect = 1'b0;
    check("t4_flushed", D_Valid, 1'b0);
    check("t4_cnt0", dbg_count, 3'd0);
    check("t4_hold_addr", IMem_Addr, 32'hC);
    check("t4_discard", dbg_discard, 1'b1);
    next();
    ack_en = 1'b1; data_force_en = 1'b1; data_force = 32'h0000_DEAD;
    next();
    data_force_en = 1'b0;
    check("t4_new_addr", IMem_Addr, 32'h40);
    check("t4_no_dead", D_Valid, 1'b0);
    check("t4_fetch", dbg_discard, 1'b0);
    D_Ready = 1'b1;
    next();
    check("t4_pc40", D_PC, 32'h40);
    check("t4_inst40", D_Inst, 32'hA5A5_0040);

    // 5: redirect coinciding with ack and pop
    apply_reset();
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b1;
    repeat (4) next();
    check("t5_addr10", IMem_Addr, 32'h10);
    check("t5_valid", D_Valid, 1'b1);
    Redirect = 1'b1; RedirTarget = 32'h80;
    next();
    Redirect = 1'b0;
    check("t5_empty", D_Valid, 1'b0);
    check("t5_addr80", IMem_Addr, 32'h80);
    check("t5_req", IMem_Req, 1'b1);
    check("t5_no_discard", dbg_discard, 1'b0);
    next();
    check("t5_pc80", D_PC, 32'h80);

    // 6: asynchronous reset mid-wait with two queued entries
    apply_reset();
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b0;
    next();
    next();
    ack_en = 1'b0;
    next();
    check("t6_cnt2", dbg_count, 3'd2);
    check("t6_wait_addr", IMem_Addr, 32'h8);
    #2;
    Rst_n = 1'b0;
    #1;
    check("t6_async_valid", D_Valid, 1'b0);
    check("t6_async_req", IMem_Req, 1'b0);
    ack_en = 1'b1;
    next();
    next();
    check("t6_stale_cnt", dbg_count, 3'd0);
    Rst_n = 1'b1;
    next();
    check("t6_restart_pc", D_PC, 32'h0);
    check("t6_restart_inst", D_Inst, 32'hA5A5_0000);

    // 7: fetch address wraps past 2^32
    apply_reset();
    Rst_n = 1'b1; ack_en = 1'b1; D_Ready = 1'b1;
    Redirect = 1'b1; RedirTarget = 32'hFFFF_FFFC;
    next();
    Redirect = 1'b0;
    check("t7_addr", IMem_Addr, 32'hFFFF_FFFC);
    check("t7_empty", D_Valid, 1'b0);
    next();
    check("t7_pc", D_PC, 32'hFFFF_FFFC);
    check("t7_pc4", D_PC4, 32'h0);
    check("t7_inst", D_Inst, 32'h5A5A_FFFC);
    check("t7_wrap_addr", IMem_Addr, 32'h0);
    next();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
